// File: rtl/sr_bank_arbiter.sv
// ---------------------------------------------------------------------------
// sr_bank_arbiter
//
// Purpose:
//   Arbitrates write access from two requesters to a bank of WIDTH SR
//   flip-flops. The winner's data is turned into per-bit set/reset drives
//   that are presented for one cycle before the bank enable rises. The
//   enable is held for PULSE_CYCLES cycles. The drives stay stable for one
//   cycle after the enable falls, so the bank never sees s/r move while it
//   is latching.
//
// Ports:
//   clk_i           rising-edge clock
//   rst_i           asynchronous active-high reset
//   req0_i, req1_i  write requests, held high until the matching grant
//   data0_i,data1_i write values, valid while the matching request is high
//   gnt0_o, gnt1_o  one-cycle grant pulses (high during SETUP)
//   s_o, r_o        per-bit set / reset drives to the bank (never both high)
//   en_o            bank latch enable, high only in PULSE
//   busy_o          high whenever a transaction is in progress
//   done_o          one-cycle completion pulse (HOLD)
// ---------------------------------------------------------------------------
module sr_bank_arbiter #(
    parameter int WIDTH        = 4,
    parameter int PULSE_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] r_o,
    output logic             en_o,
    output logic             busy_o,
    output logic             done_o
);

    // The pulse counter counts the remaining PULSE cycles after the current
    // one, so it is loaded with PULSE_CYCLES-1 and PULSE exits on zero.
    localparam logic [3:0] CNT_LOAD = 4'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e           state_q;
    logic             lastGnt_q;    // 0: requester 0 granted last, 1: requester 1
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] captured_q;   // word captured at grant, drives s directly
    logic [WIDTH-1:0] rDrive_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;

    logic             anyReq_d;
    logic             winner_d;     // 0: requester 0 wins, 1: requester 1 wins
    logic [WIDTH-1:0] winData_d;

    // Round-robin pick: on a tie the requester that was not granted last
    // wins; a lone request wins regardless of history.
    always_comb begin
        anyReq_d  = req0_i | req1_i;
        winner_d  = 1'b0;
        if (req0_i && req1_i) begin
            winner_d = ~lastGnt_q;
        end else if (req1_i) begin
            winner_d = 1'b1;
        end
        winData_d = winner_d ? data1_i : data0_i;
    end

    // Sequencer and all outputs live in one registered block so that every
    // output changes only on a clock edge (or on reset). s and r are loaded
    // together from the captured word and cleared together on return to
    // IDLE, which keeps s & r at zero in every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lastGnt_q  <= 1'b1;
            cnt_q      <= 4'd0;
            captured_q <= '0;
            rDrive_q   <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    en_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (anyReq_d) begin
                        state_q    <= SETUP;
                        captured_q <= winData_d;
                        rDrive_q   <= ~winData_d;
                        gnt0_q     <= ~winner_d;
                        gnt1_q     <= winner_d;
                        lastGnt_q  <= winner_d;
                        busy_q     <= 1'b1;
                    end
                end

                SETUP: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    en_q    <= 1'b1;
                    cnt_q   <= CNT_LOAD;
                    state_q <= PULSE;
                end

                PULSE: begin
                    if (cnt_q == 4'd0) begin
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                HOLD: begin
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    captured_q <= '0;
                    rDrive_q   <= '0;
                    state_q    <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0_o = gnt0_q;
    assign gnt1_o = gnt1_q;
    assign s_o    = captured_q;
    assign r_o    = rDrive_q;
    assign en_o   = en_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sr_bank_arbiter
//
// Two arbiter instances run side by side: instance 0 with a one-cycle
// enable pulse and instance 1 with a three-cycle pulse. A transaction-level
// model tracks, per instance, whether a transaction is open, how many cycles
// into it we are and which word was captured. The expected outputs follow
// from that position alone.
// ---------------------------------------------------------------------------
module tb_sr_bank_arbiter;

    localparam int PC0 = 1;
    localparam int PC1 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0  [2];
    logic       req1  [2];
    logic [3:0] data0 [2];
    logic [3:0] data1 [2];
    logic       gnt0  [2];
    logic       gnt1  [2];
    logic [3:0] s     [2];
    logic [3:0] r     [2];
    logic       en    [2];
    logic       busy  [2];
    logic       done  [2];

    int checksTotal  = 0;
    int checksPassed = 0;

    // Transaction-level reference model state, one entry per instance.
    bit         mActive [2] = '{0, 0};
    int         mT      [2] = '{0, 0};
    logic [3:0] mCap    [2] = '{4'd0, 4'd0};
    int         mLast   [2] = '{1, 1};
    int         mWin    [2] = '{0, 0};

    sr_bank_arbiter #(.WIDTH(4), .PULSE_CYCLES(PC0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0[0]), .req1_i(req1[0]),
        .data0_i(data0[0]), .data1_i(data1[0]),
        .gnt0_o(gnt0[0]), .gnt1_o(gnt1[0]),
        .s_o(s[0]), .r_o(r[0]),
        .en_o(en[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    sr_bank_arbiter #(.WIDTH(4), .PULSE_CYCLES(PC1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0[1]), .req1_i(req1[1]),
        .data0_i(data0[1]), .data1_i(data1[1]),
        .gnt0_o(gnt0[1]), .gnt1_o(gnt1[1]),
        .s_o(s[1]), .r_o(r[1]),
        .en_o(en[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic int pulseOf(input int i);
        return (i == 0) ? PC0 : PC1;
    endfunction

    // Single comparison point; every check in the bench goes through here.
    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic void failBound(input string name);
        checksTotal++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endfunction

    // Model update: a transaction lasts PULSE+2 cycles (position 0 is the
    // grant cycle, 1..P the enable cycles, P+1 the done cycle), after which
    // at least one idle cycle passes before the next arbitration.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mActive[i] = 0;
                mT[i]      = 0;
                mCap[i]    = 4'd0;
                mLast[i]   = 1;
            end else if (mActive[i]) begin
                mT[i]++;
                if (mT[i] > pulseOf(i) + 1) mActive[i] = 0;
            end else if (req0[i] || req1[i]) begin
                if (req0[i] && req1[i]) mWin[i] = (mLast[i] == 0) ? 1 : 0;
                else                    mWin[i] = req1[i] ? 1 : 0;
                mCap[i]    = (mWin[i] == 1) ? data1[i] : data0[i];
                mLast[i]   = mWin[i];
                mActive[i] = 1;
                mT[i]      = 0;
            end
        end
    end

    // Every falling edge: compare both instances against the model and
    // check the safety properties that must hold in every cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic       eGnt0, eGnt1, eEn, eDone;
            logic [3:0] eS, eR;
            eGnt0 = mActive[i] && mT[i] == 0 && mWin[i] == 0;
            eGnt1 = mActive[i] && mT[i] == 0 && mWin[i] == 1;
            eEn   = mActive[i] && mT[i] >= 1 && mT[i] <= pulseOf(i);
            eDone = mActive[i] && mT[i] == pulseOf(i) + 1;
            eS    = mActive[i] ? mCap[i] : 4'd0;
            eR    = mActive[i] ? ~mCap[i] : 4'd0;
            checkOutput($sformatf("i%0d.gnt0", i), 32'(gnt0[i]), 32'(eGnt0));
            checkOutput($sformatf("i%0d.gnt1", i), 32'(gnt1[i]), 32'(eGnt1));
            checkOutput($sformatf("i%0d.s", i),    32'(s[i]),    32'(eS));
            checkOutput($sformatf("i%0d.r", i),    32'(r[i]),    32'(eR));
            checkOutput($sformatf("i%0d.en", i),   32'(en[i]),   32'(eEn));
            checkOutput($sformatf("i%0d.busy", i), 32'(busy[i]), 32'(mActive[i]));
            checkOutput($sformatf("i%0d.done", i), 32'(done[i]), 32'(eDone));
            checkOutput($sformatf("i%0d.s_and_r", i), 32'(s[i] & r[i]), 32'd0);
            checkOutput($sformatf("i%0d.en_no_busy", i), 32'(en[i] & ~busy[i]), 32'd0);
            checkOutput($sformatf("i%0d.onehot_gnt_done", i),
                        32'(int'(gnt0[i]) + int'(gnt1[i]) + int'(done[i]) > 1), 32'd0);
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic r0, input logic [3:0] d0,
                                 input logic r1, input logic [3:0] d1);
        req0[i]  = r0;
        data0[i] = d0;
        req1[i]  = r1;
        data1[i] = d1;
    endtask

    // Waits for a grant on instance i; returns 0/1 for the winner, -1 on timeout.
    task automatic waitGrant(input int i, input int budget, output int who);
        who = -1;
        for (int c = 0; c < budget; c++) begin
            if (gnt0[i]) begin who = 0; return; end
            if (gnt1[i]) begin who = 1; return; end
            waitCycle();
        end
    endtask

    // Directed scenarios with hand-computed expectations, then a long run of
    // random requesters that hold their request until granted.
    initial begin
        int busyCnt [2];
        int enCnt   [2];
        int enFirst [2];
        int enLast  [2];
        int doneAt  [2];
        int srBad   [2];
        logic [3:0] capA [2];
        int grantWho [4];
        int grantAt  [4];
        int nGrant;
        int who;

        rst = 1'b1;
        applyStimulus(0, 1'b0, 4'd0, 1'b0, 4'd0);
        applyStimulus(1, 1'b0, 4'd0, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset.i%0d.busy", i), 32'(busy[i]), 32'd0);
            checkOutput($sformatf("reset.i%0d.s", i),    32'(s[i]),    32'd0);
            checkOutput($sformatf("reset.i%0d.en", i),   32'(en[i]),   32'd0);
        end
        rst = 1'b0;

        // Single request on each instance: short pulse on 0, long pulse on 1.
        $display("[TB] single request / long pulse");
        capA[0] = 4'b1010;
        capA[1] = 4'b0011;
        applyStimulus(0, 1'b1, 4'b1010, 1'b0, 4'd0);
        applyStimulus(1, 1'b0, 4'd0, 1'b1, 4'b0011);
        waitCycle();
        checkOutput("single.gnt0", 32'(gnt0[0]), 32'd1);
        checkOutput("single.s",    32'(s[0]),    32'b1010);
        checkOutput("single.r",    32'(r[0]),    32'b0101);
        checkOutput("single.en",   32'(en[0]),   32'd0);
        checkOutput("long.gnt1",   32'(gnt1[1]), 32'd1);
        req0[0] = 1'b0;
        req1[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            busyCnt[i] = 0; enCnt[i] = 0; enFirst[i] = -1; enLast[i] = -1;
            doneAt[i] = -1; srBad[i] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (busy[i]) busyCnt[i]++;
                if (en[i]) begin
                    enCnt[i]++;
                    if (enFirst[i] < 0) enFirst[i] = k;
                    enLast[i] = k;
                end
                if (done[i]) doneAt[i] = k;
                if (busy[i] && (s[i] != capA[i] || r[i] != ~capA[i])) srBad[i]++;
            end
            if (k == 1) data0[0] = 4'b1111;
            if (k == 2) data1[1] = 4'b1100;
            waitCycle();
        end
        checkOutput("single.busyCycles", 32'(busyCnt[0]), 32'd3);
        checkOutput("single.enCycles",   32'(enCnt[0]),   32'd1);
        checkOutput("single.doneAt",     32'(doneAt[0]),  32'd2);
        checkOutput("single.srHeld",     32'(srBad[0]),   32'd0);
        checkOutput("long.busyCycles",   32'(busyCnt[1]), 32'd5);
        checkOutput("long.enCycles",     32'(enCnt[1]),   32'd3);
        checkOutput("long.enFirst",      32'(enFirst[1]), 32'd1);
        checkOutput("long.enLast",       32'(enLast[1]),  32'd3);
        checkOutput("long.doneAt",       32'(doneAt[1]),  32'd4);
        checkOutput("long.srHeld",       32'(srBad[1]),   32'd0);

        // Tie fairness after a fresh reset: both held high for four grants.
        $display("[TB] tie fairness");
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 4'b0110, 1'b1, 4'b1001);
        nGrant = 0;
        for (int c = 0; c < 40 && nGrant < 4; c++) begin
            if (gnt0[0] || gnt1[0]) begin
                grantWho[nGrant] = gnt1[0] ? 1 : 0;
                grantAt[nGrant]  = c;
                nGrant++;
            end
            waitCycle();
        end
        applyStimulus(0, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("tie.count", 32'(nGrant), 32'd4);
        if (nGrant == 4) begin
            for (int g = 0; g < 4; g++)
                checkOutput($sformatf("tie.who%0d", g), 32'(grantWho[g]), 32'(g % 2));
            for (int g = 1; g < 4; g++)
                checkOutput($sformatf("tie.gap%0d", g), 32'(grantAt[g] - grantAt[g-1]), 32'd4);
        end
        repeat (4) waitCycle();

        // Reset during PULSE on the long-pulse instance.
        $display("[TB] reset in pulse");
        applyStimulus(1, 1'b0, 4'd0, 1'b1, 4'b0110);
        waitGrant(1, 10, who);
        if (who < 0) failBound("rstPulse.grant");
        req1[1] = 1'b0;
        waitCycle();
        checkOutput("rstPulse.enBefore", 32'(en[1]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstPulse.en",   32'(en[1]),   32'd0);
        checkOutput("rstPulse.s",    32'(s[1]),    32'd0);
        checkOutput("rstPulse.r",    32'(r[1]),    32'd0);
        checkOutput("rstPulse.busy", 32'(busy[1]), 32'd0);
        checkOutput("rstPulse.done", 32'(done[1]), 32'd0);
        waitCycle();
        checkOutput("rstPulse.doneLater", 32'(done[1]), 32'd0);
        rst = 1'b0;
        applyStimulus(1, 1'b1, 4'b0101, 1'b1, 4'b1110);
        waitGrant(1, 10, who);
        if (who < 0) failBound("rstPulse.tieGrant");
        else checkOutput("rstPulse.firstTie", 32'(who), 32'd0);
        applyStimulus(1, 1'b0, 4'd0, 1'b0, 4'd0);
        repeat (6) waitCycle();

        // Random requesters with occasional asynchronous resets.
        $display("[TB] random phase");
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (gnt0[i]) begin
                    if ($urandom_range(0, 9) < 7) req0[i] = 1'b0;
                end else if (!req0[i] && $urandom_range(0, 9) < 4) begin
                    req0[i]  = 1'b1;
                    data0[i] = 4'($urandom);
                end
                if (gnt1[i]) begin
                    if ($urandom_range(0, 9) < 7) req1[i] = 1'b0;
                end else if (!req1[i] && $urandom_range(0, 9) < 4) begin
                    req1[i]  = 1'b1;
                    data1[i] = 4'($urandom);
                end
                if ($urandom_range(0, 9) < 2) data0[i] = 4'($urandom);
                if ($urandom_range(0, 9) < 2) data1[i] = 4'($urandom);
            end
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                waitCycle();
            end
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/sr_bank_arbiter.md
SR_BANK_ARBITER -- requirements
Module: sr_bank_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, is the number of SR flip-flop bits in the controlled bank.
REQ-002 Parameter PULSE_CYCLES, default 1, range 1..15, is the number of cycles the bank enable is held high per write.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port req0, input, 1: write request from requester 0; held high until gnt0 is seen.
REQ-006 Port req1, input, 1: write request from requester 1; held high until gnt1 is seen.
REQ-007 Port data0, input, WIDTH: requester 0 write value; valid while req0 is high.
REQ-008 Port data1, input, WIDTH: requester 1 write value; valid while req1 is high.
REQ-009 Port gnt0 / gnt1, output, 1 each: one-cycle grant pulse to the winning requester.
REQ-010 Port s, output, WIDTH: per-bit set drive to the bank.
REQ-011 Port r, output, WIDTH: per-bit reset drive to the bank.
REQ-012 Port en, output, 1: bank latch enable.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETUP, PULSE and HOLD.
REQ-016 IDLE: with any req high at a clock edge, SHALL move to SETUP, capture the winner's data into a WIDTH-bit register, and assert the winner's gnt for exactly the SETUP cycle.
REQ-017 IDLE with no request SHALL stay in IDLE; s, r and en SHALL be all-zero.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; with one request high, that requester wins regardless of history.
REQ-019 The last-granted pointer SHALL update only on a grant.
REQ-020 SETUP SHALL last one cycle with s = captured, r = ~captured and en = 0, then go to PULSE.
REQ-021 PULSE SHALL keep s and r unchanged, drive en = 1, and last exactly PULSE_CYCLES cycles using a down-counter loaded on entry, then go to HOLD.
REQ-022 HOLD SHALL last one cycle with s and r unchanged, en = 0 and done = 1, then go to IDLE.
REQ-023 Each transaction SHALL be busy for 2 + PULSE_CYCLES cycles; the next grant can come no earlier than one IDLE cycle after HOLD.
REQ-024 For every bit and in every cycle, s[i] & r[i] SHALL be 0.
REQ-025 en SHALL be 1 only in PULSE, so s and r are stable for at least one cycle before and after en.
REQ-026 Changes on req or data while busy SHALL be ignored; a request still high on return to IDLE is arbitrated normally.
REQ-027 gnt0 and gnt1 SHALL never be high together, and done SHALL never be high together with either gnt.

Reset
REQ-028 While rst is high, regardless of clk: state = IDLE; s, r, en, gnt0, gnt1, busy and done = 0; captured data = 0; pulse counter = 0; pointer set so that requester 0 wins the first tie.
REQ-029 Reset asserted mid-transaction, including during PULSE, SHALL drop en in the same instant, with no done pulse.
REQ-030 The first arbitration SHALL occur at the first rising edge after rst deasserts.

Verification
REQ-031 Single request: req0=1, data0=4'b1010, PULSE_CYCLES=1 -> gnt0 pulses in SETUP; s=1010 and r=0101 for 3 cycles; en high 1 cycle; done in cycle 3; busy for 3 cycles.
REQ-032 Tie fairness: req0 and req1 both held high through 4 transactions -> grants go 0,1,0,1; each grant is separated by an IDLE cycle.
REQ-033 Long pulse: PULSE_CYCLES=3, req1=1, data1=4'b0011 -> en high exactly 3 consecutive cycles; busy 5 cycles; s/r constant throughout.
REQ-034 Data change while busy: data0 changes to 4'b1111 during PULSE -> s and r hold the value captured at grant.
REQ-035 Reset in PULSE: rst asserted mid-PULSE -> en, s, r and busy go 0 immediately with no done; after release, req1 and req0 both high -> gnt0 first.
REQ-036 Assertion over all tests: s & r == 0 every cycle; en implies busy; at most one of gnt0, gnt1, done high per cycle.
